// File: rtl/approx_adder_error_monitor_if.sv
// Tuple stream from the adder under evaluation: operands, carry-in and the approximate result.
// A tuple moves when in_valid and in_ready are both high; the monitor owns in_ready.
interface approx_adder_error_monitor_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic [WIDTH-1:0] in_sum;
  logic             in_cout;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sum, in_cout,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sum, in_cout,
    output in_ready
  );
endinterface

// File: rtl/approx_adder_error_monitor.sv
// Recomputes exact sums for approximate-adder tuples and accumulates error statistics.
// Stats land 2 edges after acceptance, one tuple per cycle; in_ready is high only in RUN.
module approx_adder_error_monitor #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       stop,
  approx_adder_error_monitor_if.slave tup,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_W-1:0]           sample_cnt,
  output logic [CNT_W-1:0]           err_cnt,
  output logic [WIDTH:0]             max_ed,
  output logic [CNT_W+WIDTH:0]       sum_ed,
  output logic                       first_err_valid,
  output logic [WIDTH-1:0]           first_err_a,
  output logic [WIDTH-1:0]           first_err_b
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int SUM_W = CNT_W + WIDTH + 1;

  logic [1:0] state_q, state_d;

  logic             s1_vld_q;
  logic [WIDTH:0]   s1_exact_q;
  logic [WIDTH:0]   s1_approx_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;

  logic             s2_vld_q;
  logic [WIDTH:0]   s2_ed_q;
  logic [WIDTH-1:0] s2_a_q, s2_b_q;

  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [WIDTH:0]   max_ed_q, max_ed_d;
  logic [SUM_W-1:0] sum_ed_q, sum_ed_d;
  logic             fe_vld_q, fe_vld_d;
  logic [WIDTH-1:0] fe_a_q, fe_a_d;
  logic [WIDTH-1:0] fe_b_q, fe_b_d;

  logic             accept;
  logic             clear_stats;
  logic [WIDTH:0]   exact_d;
  logic [WIDTH:0]   approx_d;
  logic [WIDTH:0]   ed_d;
  logic [SUM_W:0]   sum_ext;

  assign tup.in_ready = (state_q == ST_RUN);
  assign accept       = tup.in_valid & tup.in_ready;
  assign clear_stats  = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));

  assign busy = (state_q == ST_RUN) | (state_q == ST_DRAIN);
  assign done = (state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (stop)  state_d = ST_DRAIN;
      // Nothing enters stage 1 in DRAIN, so once it is empty stage 2 retires on this same edge.
      ST_DRAIN: if (!s1_vld_q) state_d = ST_DONE;
      ST_DONE:  if (start) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign exact_d  = {1'b0, tup.in_a} + {1'b0, tup.in_b} + {{WIDTH{1'b0}}, tup.in_cin};
  assign approx_d = {tup.in_cout, tup.in_sum};

  assign ed_d = (s1_exact_q >= s1_approx_q) ? (s1_exact_q - s1_approx_q)
                                            : (s1_approx_q - s1_exact_q);

  assign sum_ext = {1'b0, sum_ed_q} + {{(CNT_W + 1){1'b0}}, s2_ed_q};

  always_comb begin
    sample_cnt_d = sample_cnt_q;
    err_cnt_d    = err_cnt_q;
    max_ed_d     = max_ed_q;
    sum_ed_d     = sum_ed_q;
    fe_vld_d     = fe_vld_q;
    fe_a_d       = fe_a_q;
    fe_b_d       = fe_b_q;
    if (clear_stats) begin
      sample_cnt_d = '0;
      err_cnt_d    = '0;
      max_ed_d     = '0;
      sum_ed_d     = '0;
      fe_vld_d     = 1'b0;
      fe_a_d       = '0;
      fe_b_d       = '0;
    end else if (s2_vld_q) begin
      // All accumulators stick at all-ones rather than wrapping.
      if (!(&sample_cnt_q)) sample_cnt_d = sample_cnt_q + {{(CNT_W - 1){1'b0}}, 1'b1};
      if (s2_ed_q != '0) begin
        if (!(&err_cnt_q)) err_cnt_d = err_cnt_q + {{(CNT_W - 1){1'b0}}, 1'b1};
        if (!fe_vld_q) begin
          fe_vld_d = 1'b1;
          fe_a_d   = s2_a_q;
          fe_b_d   = s2_b_q;
        end
      end
      sum_ed_d = sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
      if (s2_ed_q > max_ed_q) max_ed_d = s2_ed_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      s1_vld_q    <= 1'b0;
      s1_exact_q  <= '0;
      s1_approx_q <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s2_vld_q    <= 1'b0;
      s2_ed_q     <= '0;
      s2_a_q      <= '0;
      s2_b_q      <= '0;
    end else begin
      state_q  <= state_d;
      s1_vld_q <= accept;
      if (accept) begin
        s1_exact_q  <= exact_d;
        s1_approx_q <= approx_d;
        s1_a_q      <= tup.in_a;
        s1_b_q      <= tup.in_b;
      end
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_ed_q <= ed_d;
        s2_a_q  <= s1_a_q;
        s2_b_q  <= s1_b_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      max_ed_q     <= '0;
      sum_ed_q     <= '0;
      fe_vld_q     <= 1'b0;
      fe_a_q       <= '0;
      fe_b_q       <= '0;
    end else begin
      sample_cnt_q <= sample_cnt_d;
      err_cnt_q    <= err_cnt_d;
      max_ed_q     <= max_ed_d;
      sum_ed_q     <= sum_ed_d;
      fe_vld_q     <= fe_vld_d;
      fe_a_q       <= fe_a_d;
      fe_b_q       <= fe_b_d;
    end
  end

  assign sample_cnt      = sample_cnt_q;
  assign err_cnt         = err_cnt_q;
  assign max_ed          = max_ed_q;
  assign sum_ed          = sum_ed_q;
  assign first_err_valid = fe_vld_q;
  assign first_err_a     = fe_a_q;
  assign first_err_b     = fe_b_q;

endmodule
